// File: rtl/nanov_spi_ram.sv
// rtl/nanov_spi_ram.sv - SPI RAM responder (READ 0x03 / WRITE 0x02) with backdoor port.
// Optional FAST READ (0x0B, 8 dummy edges) enabled by NANOV_SPI_RAM_FAST_READ_EN.
module nanov_spi_ram #(
   parameter int ADDR_BITS = 12
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 spi_select,
   input  logic                 spi_clk_enable,
   input  logic                 spi_mosi,
   output logic                 spi_miso,
   input  logic                 bd_we,
   input  logic [ADDR_BITS-1:0] bd_addr,
   input  logic [7:0]           bd_wdata,
   output logic [7:0]           bd_rdata,
   output logic                 active
);
   localparam logic [2:0] ST_CMD    = 3'd0;
   localparam logic [2:0] ST_ADDR   = 3'd1;
   localparam logic [2:0] ST_RDATA  = 3'd2;
   localparam logic [2:0] ST_WDATA  = 3'd3;
   localparam logic [2:0] ST_IGNORE = 3'd4;
   localparam logic [2:0] ST_DUMMY  = 3'd5;

   logic [7:0]           mem [0:(1<<ADDR_BITS)-1];
   logic [2:0]           state;
   logic [4:0]           bit_cnt;
   logic [23:0]          sh;
   logic [ADDR_BITS-1:0] addr;
   logic                 is_write;
   logic                 is_fast;

   logic                 bit_edge;
   logic [23:0]          sh_in;
   logic [ADDR_BITS-1:0] addr_in;
   logic [ADDR_BITS-1:0] addr_nxt;
   logic [7:0]           rd_entry;
   logic [7:0]           rd_cur;
   logic [7:0]           rd_next;
   logic                 spi_we;
   logic                 fast_cmd;

   assign bit_edge = !spi_select && spi_clk_enable;
   assign sh_in    = {sh[22:0], spi_mosi};
   assign addr_in  = sh_in[ADDR_BITS-1:0];
   assign addr_nxt = addr + {{(ADDR_BITS-1){1'b0}}, 1'b1};
   assign rd_entry = mem[addr_in];
   assign rd_cur   = mem[addr];
   assign rd_next  = mem[addr_nxt];
   assign spi_we   = bit_edge && (state == ST_WDATA) && (bit_cnt == 5'd7);
   assign active   = (state == ST_ADDR) || (state == ST_RDATA) ||
                     (state == ST_WDATA) || (state == ST_DUMMY);

`ifdef NANOV_SPI_RAM_FAST_READ_EN
   assign fast_cmd = (sh_in[7:0] == 8'h0B);
`else
   assign fast_cmd = 1'b0;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= ST_CMD;
         bit_cnt  <= 5'd0;
         sh       <= 24'h0;
         addr     <= '0;
         is_write <= 1'b0;
         is_fast  <= 1'b0;
         spi_miso <= 1'b0;
      end else if (spi_select) begin
         state    <= ST_CMD;
         bit_cnt  <= 5'd0;
         sh       <= 24'h0;
         spi_miso <= 1'b0;
      end else if (spi_clk_enable) begin
         case (state)
            ST_CMD: begin
               sh <= sh_in;
               if (bit_cnt == 5'd7) begin
                  bit_cnt <= 5'd0;
                  if (sh_in[7:0] == 8'h03 || sh_in[7:0] == 8'h02 || fast_cmd) begin
                     state    <= ST_ADDR;
                     is_write <= (sh_in[7:0] == 8'h02);
                     is_fast  <= fast_cmd;
                  end else begin
                     state <= ST_IGNORE;
                  end
               end else begin
                  bit_cnt <= bit_cnt + 5'd1;
               end
            end
            ST_ADDR: begin
               sh <= sh_in;
               if (bit_cnt == 5'd23) begin
                  bit_cnt <= 5'd0;
                  addr    <= addr_in;
                  if (is_write) begin
                     state <= ST_WDATA;
                  end else if (is_fast) begin
                     state <= ST_DUMMY;
                  end else begin
                     // Zero-latency read: first data bit goes out on the address-bit-0 edge
                     state    <= ST_RDATA;
                     sh       <= {16'h0, rd_entry};
                     spi_miso <= rd_entry[7];
                  end
               end else begin
                  bit_cnt <= bit_cnt + 5'd1;
               end
            end
            ST_DUMMY: begin
               if (bit_cnt == 5'd7) begin
                  bit_cnt  <= 5'd0;
                  state    <= ST_RDATA;
                  sh       <= {16'h0, rd_cur};
                  spi_miso <= rd_cur[7];
               end else begin
                  bit_cnt <= bit_cnt + 5'd1;
               end
            end
            ST_RDATA: begin
               if (bit_cnt == 5'd7) begin
                  bit_cnt  <= 5'd0;
                  addr     <= addr_nxt;
                  sh       <= {16'h0, rd_next};
                  spi_miso <= rd_next[7];
               end else begin
                  bit_cnt  <= bit_cnt + 5'd1;
                  sh       <= {sh[22:0], 1'b0};
                  spi_miso <= sh[6];
               end
            end
            ST_WDATA: begin
               sh <= sh_in;
               if (bit_cnt == 5'd7) begin
                  bit_cnt <= 5'd0;
                  addr    <= addr_nxt;
               end else begin
                  bit_cnt <= bit_cnt + 5'd1;
               end
            end
            ST_IGNORE: begin
               spi_miso <= 1'b0;
            end
            default: begin
               state <= ST_CMD;
            end
         endcase
      end
   end

   // SPI write is assigned last so it wins a same-address collision with the backdoor
   always_ff @(posedge clk) begin
      if (bd_we) mem[bd_addr] <= bd_wdata;
      if (spi_we) mem[addr] <= sh_in[7:0];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) bd_rdata <= 8'h0;
      else       bd_rdata <= mem[bd_addr];
   end
endmodule

// File: tb/tb_nanov_spi_ram.sv
// tb/tb_nanov_spi_ram.sv - scoreboard bench for nanov_spi_ram.
module tb_nanov_spi_ram;
   localparam int AB = 12;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          spi_select = 1'b1;
   logic          spi_clk_enable = 1'b0;
   logic          spi_mosi = 1'b0;
   logic          spi_miso;
   logic          bd_we = 1'b0;
   logic [AB-1:0] bd_addr = '0;
   logic [7:0]    bd_wdata = 8'h0;
   logic [7:0]    bd_rdata;
   logic          active;

   int            checks = 0;
   int            errors = 0;
   logic [7:0]    exp_q [$];

   nanov_spi_ram #(.ADDR_BITS(AB)) dut (
      .clk(clk), .rstn(rstn), .spi_select(spi_select), .spi_clk_enable(spi_clk_enable),
      .spi_mosi(spi_mosi), .spi_miso(spi_miso), .bd_we(bd_we), .bd_addr(bd_addr),
      .bd_wdata(bd_wdata), .bd_rdata(bd_rdata), .active(active)
   );

   always #5 clk = ~clk;

   task automatic put(input logic sel, input logic ce, input logic mosi);
      @(negedge clk);
      spi_select = sel;
      spi_clk_enable = ce;
      spi_mosi = mosi;
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) put(1'b0, 1'b1, b[i]);
   endtask

   task automatic send_addr(input logic [23:0] a);
      for (int i = 23; i >= 0; i--) put(1'b0, 1'b1, a[i]);
   endtask

   task automatic deselect();
      put(1'b1, 1'b0, 1'b0);
   endtask

   task automatic bd_wr(input logic [AB-1:0] a, input logic [7:0] d);
      @(negedge clk);
      bd_we = 1'b1;
      bd_addr = a;
      bd_wdata = d;
      @(posedge clk);
      #1;
      bd_we = 1'b0;
   endtask

   task automatic bd_rd(input logic [AB-1:0] a, output logic [7:0] d);
      @(negedge clk);
      bd_addr = a;
      @(posedge clk);
      #1;
      d = bd_rdata;
   endtask

   task automatic bd_check(input logic [AB-1:0] a, input logic [7:0] e, input string name);
      logic [7:0] d;
      bd_rd(a, d);
      checks++;
      if (d !== e) begin
         errors++;
         $display("FAIL %s: bd_rdata[%0h] got %02h expected %02h", name, a, d, e);
      end
   endtask

   task automatic read_check(input int n, input string name);
      logic [7:0] got;
      logic [7:0] e;
      for (int k = 0; k < n; k++) begin
         for (int i = 7; i >= 0; i--) begin
            got[i] = spi_miso;
            put(1'b0, 1'b1, 1'b0);
         end
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: byte %0d got %02h with empty scoreboard", name, k, got);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               errors++;
               $display("FAIL %s: byte %0d got %02h expected %02h", name, k, got, e);
            end
         end
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks += 3;
      if (spi_miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", spi_miso); end
      if (active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b expected 0", active); end
      if (bd_rdata !== 8'h0) begin errors++; $display("FAIL reset_bd_rdata: got %02h expected 00", bd_rdata); end
      @(negedge clk);
      rstn = 1'b1;
      for (int a = 0; a < (1 << AB); a++) bd_wr(a[AB-1:0], 8'h00);
   endtask

   task automatic test_write_read();
      send_byte(8'h02);
      send_addr(24'h000010);
      checks++;
      if (active !== 1'b1) begin errors++; $display("FAIL wr_active: got %b expected 1", active); end
      send_byte(8'hA5);
      send_byte(8'h3C);
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h3C);
      deselect();
      checks++;
      if (active !== 1'b0) begin errors++; $display("FAIL desel_active: got %b expected 0", active); end
      send_byte(8'h03);
      send_addr(24'h000010);
      read_check(2, "write_read");
      deselect();
      bd_check(12'h010, 8'hA5, "bd_10");
      bd_check(12'h011, 8'h3C, "bd_11");
   endtask

   task automatic test_wrap();
      bd_wr(12'hFFF, 8'h11);
      bd_wr(12'h000, 8'h22);
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      send_byte(8'h03);
      send_addr(24'h000FFF);
      read_check(2, "wrap");
      deselect();
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      send_byte(8'h03);
      send_addr(24'h001FFF);
      read_check(2, "wrap_alias");
      deselect();
   endtask

   task automatic test_abort();
      logic [7:0] b2;
      b2 = 8'hC3;
      send_byte(8'h02);
      send_addr(24'h000020);
      send_byte(8'h5A);
      for (int i = 7; i >= 3; i--) put(1'b0, 1'b1, b2[i]);
      deselect();
      bd_check(12'h020, 8'h5A, "abort_full");
      bd_check(12'h021, 8'h00, "abort_partial");
   endtask

   task automatic test_pause();
      logic [7:0] e;
      logic [7:0] got;
      e = 8'h81;
      bd_wr(12'h040, e);
      send_byte(8'h03);
      send_addr(24'h000040);
      for (int i = 7; i >= 0; i--) begin
         got[i] = spi_miso;
         if (i == 5) begin
            for (int p = 0; p < 3; p++) begin
               put(1'b0, 1'b0, 1'b1);
               checks++;
               if (spi_miso !== e[5]) begin
                  errors++;
                  $display("FAIL pause_hold: cycle %0d got %b expected %b", p, spi_miso, e[5]);
               end
            end
         end
         put(1'b0, 1'b1, 1'b0);
      end
      checks++;
      if (got !== e) begin errors++; $display("FAIL pause_byte: got %02h expected %02h", got, e); end
      deselect();
   endtask

   task automatic test_unknown();
      logic [39:0] s;
      s = {8'h9F, 32'($urandom)};
      for (int i = 39; i >= 0; i--) begin
         put(1'b0, 1'b1, s[i]);
         checks++;
         if (spi_miso !== 1'b0 || active !== 1'b0) begin
            errors++;
            $display("FAIL unknown_cmd: bit %0d miso %b active %b expected 0 0", i, spi_miso, active);
         end
      end
      deselect();
      bd_check(12'h040, 8'h81, "unknown_mem40");
      bd_check(12'h010, 8'hA5, "unknown_mem10");
   endtask

   task automatic test_fast_read();
      send_byte(8'h0B);
      send_addr(24'h000040);
      for (int d = 0; d < 8; d++) begin
         checks++;
         if (spi_miso !== 1'b0) begin
            errors++;
            $display("FAIL fast_dummy: edge %0d got %b expected 0", d, spi_miso);
         end
         put(1'b0, 1'b1, 1'b0);
      end
`ifdef NANOV_SPI_RAM_FAST_READ_EN
      exp_q.push_back(8'h81);
`else
      exp_q.push_back(8'h00);
`endif
      read_check(1, "fast_read");
      deselect();
   endtask

   task automatic test_back_to_back();
      logic [7:0] d;
      send_byte(8'h02);
      send_addr(24'h000100);
      for (int k = 0; k < 4; k++) begin
         d = 8'($urandom);
         send_byte(d);
         exp_q.push_back(d);
      end
      deselect();
      send_byte(8'h03);
      send_addr(24'h000100);
      read_check(4, "back_to_back");
      deselect();
   endtask

   task automatic test_collision();
      logic [7:0] b;
      b = 8'h5C;
      send_byte(8'h02);
      send_addr(24'h000300);
      for (int i = 7; i >= 1; i--) put(1'b0, 1'b1, b[i]);
      @(negedge clk);
      spi_mosi = b[0];
      bd_we = 1'b1;
      bd_addr = 12'h300;
      bd_wdata = 8'hEE;
      @(posedge clk);
      #1;
      bd_we = 1'b0;
      deselect();
      bd_check(12'h300, 8'h5C, "collision");
   endtask

   task automatic test_reset_mid();
      send_byte(8'h02);
      send_addr(24'h000200);
      send_byte(8'h77);
      put(1'b0, 1'b1, 1'b1);
      put(1'b0, 1'b1, 1'b0);
      @(negedge clk);
      rstn = 1'b0;
      #1;
      checks += 2;
      if (active !== 1'b0) begin errors++; $display("FAIL rst_mid_active: got %b expected 0", active); end
      if (spi_miso !== 1'b0) begin errors++; $display("FAIL rst_mid_miso: got %b expected 0", spi_miso); end
      @(negedge clk);
      rstn = 1'b1;
      spi_select = 1'b1;
      spi_clk_enable = 1'b0;
      bd_check(12'h200, 8'h77, "rst_mid_committed");
      bd_check(12'h201, 8'h00, "rst_mid_partial");
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_wrap();
      test_abort();
      test_pause();
      test_unknown();
      test_fast_read();
      test_back_to_back();
      test_collision();
      test_reset_mid();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
